// File: rtl/picoblaze_rtc_port_bank.sv
// PicoBlaze I/O port bank for an RTC controller: shadow/commit write registers,
// snapshot read registers, a commit handshake FSM and a registered read port.
module picoblaze_rtc_port_bank #(
  parameter int         NREG      = 9,
  parameter int         W         = 8,
  parameter logic [7:0] WR_BASE   = 8'h02,
  parameter logic [7:0] RD_BASE   = 8'h0D,
  parameter logic [7:0] CTRL_PORT = 8'h0B,
  parameter logic [7:0] STAT_PORT = 8'h0C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_strobe,
  input  logic              read_strobe,
  input  logic [7:0]        port_id,
  input  logic [W-1:0]      out_port,
  output logic [W-1:0]      in_port,
  output logic [NREG*W-1:0] reg_out,
  input  logic [NREG*W-1:0] rtc_in,
  input  logic              rtc_done,
  output logic              wr_req,
  output logic              busy
);

  localparam int WR_LO   = int'(WR_BASE);
  localparam int WR_HI   = WR_LO + NREG - 1;
  localparam int RD_LO   = int'(RD_BASE);
  localparam int RD_HI   = RD_LO + NREG - 1;
  localparam int CTRL_ID = int'(CTRL_PORT);
  localparam int STAT_ID = int'(STAT_PORT);

  localparam bit BAD_NREG  = (NREG < 1) || (NREG > 16);
  localparam bit BAD_W     = (W < 1) || (W > 8);
  localparam bit BAD_RANGE = (WR_HI > 255) || (RD_HI > 255);
  localparam bit BAD_WR_RD = (WR_LO <= RD_HI) && (RD_LO <= WR_HI);
  localparam bit BAD_CTRL  = ((CTRL_ID >= WR_LO) && (CTRL_ID <= WR_HI)) ||
                             ((CTRL_ID >= RD_LO) && (CTRL_ID <= RD_HI));
  localparam bit BAD_STAT  = ((STAT_ID >= WR_LO) && (STAT_ID <= WR_HI)) ||
                             ((STAT_ID >= RD_LO) && (STAT_ID <= RD_HI)) ||
                             (STAT_ID == CTRL_ID);

  generate
    if (BAD_NREG) begin : g_bad_nreg
      $error("picoblaze_rtc_port_bank: NREG must be in 1..16");
    end
    if (BAD_W) begin : g_bad_w
      $error("picoblaze_rtc_port_bank: W must be in 1..8");
    end
    if (BAD_RANGE) begin : g_bad_range
      $error("picoblaze_rtc_port_bank: register range exceeds port id 8'hFF");
    end
    if (BAD_WR_RD || BAD_CTRL || BAD_STAT) begin : g_bad_overlap
      $error("picoblaze_rtc_port_bank: port id ranges overlap");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state;
  logic [W-1:0]        shadow [NREG];
  logic [W-1:0]        snap   [NREG];
  logic [NREG*W-1:0]   shadow_flat;
  logic [NREG-1:0]     wr_sel;
  logic                ctrl_wr;
  logic                commit_req;
  logic                snap_req;
  logic                snap_bit;
  logic                stat_rd;
  logic                done_flag;
  logic                overrun;
  logic                done_nxt;
  logic                overrun_nxt;
  logic [W-1:0]        rd_data_p0;

  // Status word {overrun, busy, done_flag} truncated to the data width.
  function automatic logic [W-1:0] status_word(input logic ovr, input logic bsy,
                                               input logic dn);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) begin
      case (k)
        0:       r[k] = dn;
        1:       r[k] = bsy;
        2:       r[k] = ovr;
        default: r[k] = 1'b0;
      endcase
    end
    return r;
  endfunction

  generate
    if (W > 1) begin : g_snap_bit
      assign snap_bit = out_port[1];
    end else begin : g_no_snap_bit
      assign snap_bit = 1'b0;
    end
  endgenerate

  assign ctrl_wr    = write_strobe && (port_id == CTRL_PORT);
  assign commit_req = ctrl_wr && out_port[0];
  assign snap_req   = ctrl_wr && snap_bit;
  assign stat_rd    = read_strobe && (port_id == STAT_PORT);

  always_comb begin
    wr_sel      = '0;
    shadow_flat = '0;
    for (int i = 0; i < NREG; i++) begin
      wr_sel[i]             = write_strobe && (port_id == 8'(WR_LO + i));
      shadow_flat[i*W +: W] = shadow[i];
    end
  end

  always_comb begin
    rd_data_p0 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (port_id == 8'(RD_LO + i)) rd_data_p0 = snap[i];
    end
    if (port_id == STAT_PORT) rd_data_p0 = status_word(overrun, busy, done_flag);
  end

  // A flag being set in the same cycle as a status-read clear keeps the set.
  always_comb begin
    done_nxt    = done_flag;
    overrun_nxt = overrun;
    if (stat_rd) begin
      done_nxt    = 1'b0;
      overrun_nxt = 1'b0;
    end
    if (commit_req && (state == ST_IDLE)) done_nxt = 1'b0;
    if (commit_req && (state != ST_IDLE)) overrun_nxt = 1'b1;
    if ((state == ST_RELEASE) && !rtc_done) done_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        shadow[i] <= '0;
        snap[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_sel[i]) shadow[i] <= out_port;
        if (snap_req)  snap[i]   <= rtc_in[i*W +: W];
      end
    end
  end

  // Read port stage: in_port is the registered copy of rd_data_p0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wr_req    <= 1'b0;
      busy      <= 1'b0;
      reg_out   <= '0;
      done_flag <= 1'b0;
      overrun   <= 1'b0;
      in_port   <= '0;
    end else begin
      in_port   <= rd_data_p0;
      done_flag <= done_nxt;
      overrun   <= overrun_nxt;
      case (state)
        ST_IDLE: begin
          if (commit_req) begin
            reg_out <= shadow_flat;
            state   <= ST_REQ;
            wr_req  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (rtc_done) begin
            state  <= ST_RELEASE;
            wr_req <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (!rtc_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          wr_req <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/picoblaze_rtc_port_bank.md
PICOBLAZE_RTC_PORT_BANK -- requirements
Module: picoblaze_rtc_port_bank

Interface
REQ-001 Parameter NREG, default 9: number of write registers and of read registers, legal range 1..16.
REQ-002 Parameter W, default 8: register and data width, legal range 1..8.
REQ-003 Parameter WR_BASE, default 8'h02: port_id of write register 0; register i is at WR_BASE+i.
REQ-004 Parameter RD_BASE, default 8'h0D: port_id of read register 0; register i is at RD_BASE+i.
REQ-005 Parameter CTRL_PORT, default 8'h0B: control port id. Parameter STAT_PORT, default 8'h0C: status port id.
REQ-006 Elaboration SHALL fail if the WR range, RD range, CTRL_PORT or STAT_PORT overlap, or if any range exceeds 8'hFF.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 write_strobe  in  1  PicoBlaze output-instruction qualifier.
REQ-010 read_strobe  in  1  PicoBlaze input-instruction qualifier.
REQ-011 port_id  in  8  PicoBlaze port address.
REQ-012 out_port  in  W  PicoBlaze write data.
REQ-013 in_port  out  W  registered read data to PicoBlaze.
REQ-014 reg_out  out  NREG*W  committed registers to the RTC controller; register i is at bits [i*W +: W].
REQ-015 rtc_in  in  NREG*W  live values from the RTC controller, same packing as reg_out.
REQ-016 rtc_done  in  1  RTC controller write-complete level, in the clk domain.
REQ-017 wr_req  out  1  request to the RTC controller to write reg_out.
REQ-018 busy  out  1  high while a commit transaction is in progress.

Function
REQ-019 A write with write_strobe=1 and port_id=WR_BASE+i SHALL load shadow[i] from out_port[W-1:0] at the next edge; reg_out SHALL NOT change.
REQ-020 A write to CTRL_PORT SHALL decode bit0=COMMIT and bit1=SNAP; both bits set SHALL perform both actions in the same cycle.
REQ-021 Commit FSM states:
  - IDLE: wr_req=0, busy=0.
  - REQ: wr_req=1, busy=1.
  - RELEASE: wr_req=0, busy=1.
REQ-022 In IDLE, COMMIT SHALL copy all shadow[] to reg_out in one edge, enter REQ, and clear done_flag.
REQ-023 In REQ, rtc_done=1 SHALL move the FSM to RELEASE; otherwise it stays in REQ indefinitely.
REQ-024 In RELEASE, rtc_done=0 SHALL move the FSM to IDLE and set done_flag.
REQ-025 COMMIT while not in IDLE SHALL be ignored, leave reg_out unchanged, and set overrun.
REQ-026 Shadow writes during REQ or RELEASE SHALL be accepted and SHALL NOT affect reg_out until the next commit.
REQ-027 SNAP SHALL capture all rtc_in into snap[] at the next edge, in any FSM state.
REQ-028 in_port SHALL be registered with one-cycle latency, updated every cycle regardless of read_strobe:
  - port_id=RD_BASE+i gives snap[i].
  - STAT_PORT gives {5'b0, overrun, busy, done_flag}, truncated to W bits.
  - All other ids give 0.
REQ-029 read_strobe=1 with port_id=STAT_PORT SHALL clear done_flag and overrun at the same edge that in_port captures their pre-clear values.
REQ-030 A set of done_flag or overrun coinciding with a status-read clear SHALL win; the flag reads 1 afterwards.
REQ-031 Writes to RD, STAT or unmapped ids SHALL have no effect. Reads SHALL have no side effects other than REQ-029.

Reset
REQ-032 reset=0 SHALL immediately force the following to 0, independent of clk: shadow[], snap[], reg_out, in_port, done_flag, overrun, wr_req, busy.
REQ-033 reset=0 SHALL immediately force the FSM to IDLE, independent of clk.
REQ-034 Reset asserted mid-transaction SHALL abort it; wr_req SHALL drop asynchronously.
REQ-035 After reset release, the first edge SHALL behave as in IDLE.

Verification
REQ-036 Write 8'h24 to port 02 and 8'h07 to port 0A; reg_out stays 0. Then write 8'h01 to CTRL. Next edge: reg_out[7:0]=24, reg_out[71:64]=07, wr_req=1, busy=1.
REQ-037 Drive rtc_done=1 for 3 cycles, then 0. Required: wr_req falls one edge after rtc_done rises; busy falls one edge after rtc_done falls; STAT reads 8'h01, then 8'h00 on the next read.
REQ-038 Write 8'h01 to CTRL while in REQ. Required: reg_out unchanged; STAT read gives 8'h06.
REQ-039 Set rtc_in[15:8]=8'h59, write 8'h02 to CTRL, then change rtc_in to 8'h00 and read port 0E. Required: in_port=8'h59 one cycle after port_id is applied.
REQ-040 Assert reset low between edges while in REQ. Required: wr_req=0, busy=0 and reg_out=0 before the next clk edge; a subsequent commit works normally.
REQ-041 With NREG=4, W=6: a write of 8'hFF to WR_BASE+3 commits as 6'h3F on reg_out[23:18]; a read of port RD_BASE+4 returns 0.
